// File: rtl/trace_pkg.sv
// trace_pkg: shared FSM encoding and entry-width helper; TRACE_TIMESTAMP_EN appends a timestamp to each entry.
package trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_e;
  localparam int DEF_DATA_W = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  function automatic int entry_w(int data_w, int ts_w);
    return 5 * data_w + (TS_EN ? ts_w : 0);
  endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x W trace storage, one sync write port, one registered read port, no reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 80
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/trace_observer.sv
// trace_observer: pipeline trace buffer with PC trigger, post-trigger capture and valid/ready readout.
// Define TRACE_TIMESTAMP_EN to store a free-running TS_W cycle counter at the entry LSBs.
module trace_observer
  import trace_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = 16,
  parameter int POST_CNT = 4,
  parameter int TS_W     = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               sample_en_i,
  input  logic [DATA_W-1:0]                  pc_i,
  input  logic [DATA_W-1:0]                  ir_i,
  input  logic [DATA_W-1:0]                  alu_a_i,
  input  logic [DATA_W-1:0]                  alu_b_i,
  input  logic [DATA_W-1:0]                  alu_o_i,
  input  logic                               arm_i,
  input  logic [DATA_W-1:0]                  trig_pc_i,
  input  logic                               rd_ready_i,
  output logic [1:0]                         state_o,
  output logic                               done_o,
  output logic [$clog2(DEPTH):0]             fill_o,
  output logic                               rd_valid_o,
  output logic [entry_w(DATA_W, TS_W)-1:0]   rd_data_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = entry_w(DATA_W, TS_W);
  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_q, post_d;
  logic [AW:0]   fill_q, fill_d, left_q, left_d;
  logic          rd_valid_q, rd_valid_d;
  logic          wr_en, rd_en, trig;
  logic [EW-1:0] wdata, rdata;
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else      ts_q <= ts_q + 1'b1;
  end
  assign wdata = {pc_i, ir_i, alu_a_i, alu_b_i, alu_o_i, ts_q};
`else
  assign wdata = {pc_i, ir_i, alu_a_i, alu_b_i, alu_o_i};
`endif
  assign wr_en = sample_en_i && (state_q == ARMED || state_q == POST);
  assign trig  = wr_en && state_q == ARMED && pc_i == trig_pc_i;
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_d     = post_q;
    fill_d     = fill_q;
    left_d     = left_q;
    rd_valid_d = rd_valid_q;
    rd_en      = 1'b0;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      fill_d   = fill_q == (AW+1)'(DEPTH) ? fill_q : fill_q + 1'b1;
    end
    case (state_q)
      IDLE:  if (arm_i) begin
        state_d = ARMED;
        post_d  = '0;
      end
      ARMED: if (trig) state_d = POST_CNT == 0 ? DONE : POST;
      POST:  if (wr_en) begin
        post_d  = post_q + 1'b1;
        state_d = post_q == AW'(POST_CNT - 1) ? DONE : POST;
      end
      DONE:  if (arm_i) begin
        state_d    = ARMED;
        fill_d     = '0;
        rd_valid_d = 1'b0;
        post_d     = '0;
      end else begin
        // The RAM output register only reloads when its current word is free to leave.
        rd_en = left_q != '0 && (!rd_valid_q || rd_ready_i);
        if (rd_en) begin
          rd_ptr_d   = rd_ptr_q + 1'b1;
          left_d     = left_q - 1'b1;
          rd_valid_d = 1'b1;
        end else if (!rd_valid_q || rd_ready_i) begin
          rd_valid_d = 1'b0;
          fill_d     = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != DONE && state_d == DONE) begin
      rd_ptr_d = wr_ptr_d - fill_d[AW-1:0];
      left_d   = fill_d;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_q     <= '0;
      fill_q     <= '0;
      left_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_q     <= post_d;
      fill_q     <= fill_d;
      left_q     <= left_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );
  assign state_o    = state_q;
  assign done_o     = state_q == DONE;
  assign fill_o     = fill_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_valid_q ? rdata : '0;
endmodule
